// File: rtl/nibble_sub_sequencer.sv
// ---------------------------------------------------------------------------
// nibble_sub_sequencer
//
// Computes diff = a - b - bin (modulo 2^W) with a single 4-bit ripple-borrow
// subtractor slice. The slice is reused once per nibble, least significant
// nibble first, so one subtraction takes NIBBLES clock cycles in RUN.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst      : asynchronous, active-high reset
//   start    : request a subtraction; only accepted in IDLE
//   a, b     : minuend / subtrahend (W = 4*NIBBLES bits), sampled on accept
//   bin      : borrow-in to nibble 0, sampled on accept
//   busy     : high while in RUN
//   done     : one-cycle pulse in DONE; diff/bout valid
//   diff     : result, held until the next accepted start
//   bout     : borrow-out of the most significant nibble
//   nib_idx  : nibble currently processed (0 outside RUN)
//
// nib_idx is 2 bits wide, so NIBBLES is limited to 1..4.
// ---------------------------------------------------------------------------
module nibble_sub_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic [1:0]             nib_idx
);

    localparam int W = 4 * NIBBLES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

    logic [1:0]   state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         borrow_q;
    logic [W-1:0] diff_q;
    logic         bout_q;
    logic [1:0]   idx_q;

    // Full-subtractor cell: returns {borrow, diff}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic c);
        logic d;
        logic bo;
        d  = x ^ y ^ c;
        bo = (~x & y) | (~x & c) | (y & c);
        return {bo, d};
    endfunction

    // The one shared 4-bit slice: four cells chained through the borrow.
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_diff;
    logic [4:0] chain;
    logic       slice_bout;

    // NOTE: every signal driven here gets a value before any conditional or
    // loop logic, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slice_a    = a_q[{idx_q, 2'b00} +: 4];
        slice_b    = b_q[{idx_q, 2'b00} +: 4];
        slice_diff = '0;
        chain      = '0;
        chain[0]   = borrow_q;
        for (int i = 0; i < 4; i++) begin
            {chain[i+1], slice_diff[i]} = full_sub(slice_a[i], slice_b[i], chain[i]);
        end
        slice_bout = chain[4];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            idx_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= 2'd0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    diff_q[{idx_q, 2'b00} +: 4] <= slice_diff;
                    borrow_q                    <= slice_bout;
                    if (idx_q == LAST_IDX) begin
                        bout_q  <= slice_bout;
                        idx_q   <= 2'd0;  // nib_idx reads 0 in DONE
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign nib_idx = idx_q;

endmodule
